// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard / memory-latency pipeline controller:
// latency FSM state encoding, ISA opcode and function codes, and limits.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lat_state_e;

  // Longest supported memory latency; sizes the latency counters.
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  // Index of each latency FSM inside the controller.
  localparam int I_FSM = 0;
  localparam int D_FSM = 1;

  // Opcodes.
  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // Function codes for OP_RTYPE.
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // R-type arithmetic/logic instructions occupy function codes ADD..SHR.
  function automatic logic is_r_arith(input logic [3:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn <= FN_SHR);
  endfunction

endpackage

// File: rtl/mem_latency_fsm.sv
// Fixed-latency memory access tracker: IDLE -> BUSY (LAT-1 cycles) -> DONE -> IDLE.
// A latency of 1 skips BUSY entirely. abort returns a BUSY access to IDLE.
module mem_latency_fsm
  import hazard_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAT - 1);

  lat_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: starts are only accepted from IDLE; the counter saturates at LAT-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (LAT <= 1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    busy = (state_q == BUSY);
    done = (state_q == DONE);
  end

endmodule

// File: rtl/hazard_latency_ctrl.sv
// Pipeline hazard and memory-latency controller. Combines RAW / jump-register /
// load-use hazard detection with instruction and data memory latency tracking
// into prioritised stall, flush and write-enable controls.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_latency_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW          = 2,
  parameter int DATA_FORWARDING = 1,
  parameter int IMEM_LAT        = 4,
  parameter int DMEM_LAT        = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        opcode,
  input  logic [5:0]        func_code,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              reg_write_ex,
  input  logic              reg_write_mem,
  input  logic [REG_AW-1:0] dest_ex,
  input  logic [REG_AW-1:0] dest_mem,
  input  logic              mem_read_ex,
  input  logic              mem_read_mem,
  input  logic              mem_write_mem,
  input  logic [REG_AW-1:0] rt_ex,
  input  logic [REG_AW-1:0] rt_mem,
  input  logic              jump_miss,
  input  logic              branch_miss,
  output logic              stall_ifid,
  output logic              stall_idex,
  output logic              stall_exmem,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_memwb,
  output logic              pc_write,
  output logic              ir_write,
  output logic              imem_busy,
  output logic              dmem_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]       perf_dstall_cnt,
  output logic [15:0]       perf_hstall_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  localparam bit FWD_EN = (DATA_FORWARDING != 0);

  logic [1:0] fsm_start, fsm_abort, fsm_busy, fsm_done;
  logic       use_rs, use_rt, is_jr;
  logic       raw_stall, jr_stall, load_stall, hazard_stall;

  // The fetch FSM restarts whenever the PC advances; a misprediction redirects
  // the fetch, so an in-flight fetch is abandoned. Data accesses cannot be cancelled.
  assign fsm_start[I_FSM] = pc_write;
  assign fsm_abort[I_FSM] = jump_miss | branch_miss;
  assign fsm_start[D_FSM] = mem_read_mem | mem_write_mem;
  assign fsm_abort[D_FSM] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fsm
      mem_latency_fsm #(
        .LAT((gi == I_FSM) ? IMEM_LAT : DMEM_LAT)
      ) u_fsm (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (fsm_start[gi]),
        .abort  (fsm_abort[gi]),
        .busy   (fsm_busy[gi]),
        .done   (fsm_done[gi])
      );
    end
  endgenerate

  // Completion pulses are not consumed by the control logic.
  logic unused_done;
  assign unused_done = ^fsm_done;

  // While reset is held every output shows the idle default set.
  assign imem_busy = fsm_busy[I_FSM] & reset_n;
  assign dmem_busy = fsm_busy[D_FSM] & reset_n;

  // Decode which source registers the ID-stage instruction reads.
  always_comb begin
    is_jr  = (opcode == OP_RTYPE) && ((func_code == FN_JPR) || (func_code == FN_JRL));
    use_rs = is_r_arith(opcode, func_code) || (opcode == OP_LWD) || (opcode == OP_SWD) ||
             (opcode <= OP_BLZ) || is_jr || (opcode == OP_ADI) || (opcode == OP_ORI);
    use_rt = is_r_arith(opcode, func_code) || (opcode == OP_LWD) || (opcode == OP_SWD) ||
             (opcode <= OP_BLZ);
  end

  // Hazard detection: RAW stalls only without forwarding; jump-register targets
  // are needed in ID and so stall even with forwarding; load-use always stalls.
  always_comb begin
    raw_stall = !FWD_EN && (
                  (use_rs && ((reg_write_ex  && (rs_id == dest_ex)) ||
                              (reg_write_mem && (rs_id == dest_mem)))) ||
                  (use_rt && ((reg_write_ex  && (rt_id == dest_ex)) ||
                              (reg_write_mem && (rt_id == dest_mem)))));
    jr_stall  = FWD_EN && is_jr &&
                ((reg_write_ex  && (rs_id == dest_ex)) ||
                 (reg_write_mem && (rs_id == dest_mem)));
    load_stall = (use_rs || use_rt) && (
                   (mem_read_ex  && ((rs_id == rt_ex)  || (rt_id == rt_ex))) ||
                   (mem_read_mem && ((rs_id == rt_mem) || (rt_id == rt_mem))));
    hazard_stall = raw_stall || jr_stall || load_stall;
  end

  // Prioritised pipeline controls: data wait, hazard, branch, jump, fetch wait.
  always_comb begin
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_memwb = 1'b0;
    pc_write    = 1'b1;
    ir_write    = 1'b1;
    if (!reset_n) begin
      pc_write = 1'b1;
      ir_write = 1'b1;
    end else if (dmem_busy) begin
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
      flush_memwb = 1'b1;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
    end else if (hazard_stall) begin
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
    end else if (branch_miss) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (jump_miss) begin
      flush_ifid = 1'b1;
    end else if (imem_busy) begin
      flush_ifid = 1'b1;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Event order: [0] data-memory stall, [1] hazard stall, [2] redirect flush.
  logic [2:0]  perf_inc;
  logic [15:0] perf_cnt_q [3];

  assign perf_inc = {flush_ifid & ~imem_busy, hazard_stall, dmem_busy};

  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      // Saturating event counter, cleared by reset.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          perf_cnt_q[gi] <= '0;
        end else if (perf_inc[gi] && (perf_cnt_q[gi] != 16'hFFFF)) begin
          perf_cnt_q[gi] <= perf_cnt_q[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign perf_dstall_cnt = perf_cnt_q[0];
  assign perf_hstall_cnt = perf_cnt_q[1];
  assign perf_flush_cnt  = perf_cnt_q[2];
`endif

endmodule

// File: tb/tb_hazard_latency_ctrl.sv
// Scoreboard bench: each stimulus cycle pushes its hand-computed expected output
// vector; a monitor pops and compares on the falling edge.
// DUT A: forwarding, IMEM_LAT=4, DMEM_LAT=4. DUT B: no forwarding, latencies of 1.
module tb_hazard_latency_ctrl;

  // Output vector: {stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex,
  //                 flush_memwb, pc_write, ir_write, imem_busy, dmem_busy}
  localparam logic [7:0] P_DEF = 8'b0000_0011;
  localparam logic [7:0] P_DST = 8'b1110_0100;
  localparam logic [7:0] P_HAZ = 8'b1000_1000;
  localparam logic [7:0] P_BR  = 8'b0001_1011;
  localparam logic [7:0] P_JMP = 8'b0001_0011;
  localparam logic [7:0] P_IB  = 8'b0001_0000;

  localparam logic [3:0] T_LWD = 4'd7;
  localparam logic [3:0] T_ADI = 4'd4;
  localparam logic [3:0] T_JMP = 4'd9;
  localparam logic [3:0] T_RTY = 4'd15;
  localparam logic [5:0] T_ADD = 6'd0;
  localparam logic [5:0] T_JPR = 6'd25;

  bit clk;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [3:0] opcode;
  logic [5:0] func_code;
  logic [1:0] rs_id, rt_id, dest_ex, dest_mem, rt_ex, rt_mem;
  logic       reg_write_ex, reg_write_mem, mem_read_ex, mem_read_mem, mem_write_mem;
  logic       jump_miss, branch_miss;

  logic a_sif, a_sid, a_sem, a_fif, a_fid, a_fmw, a_pcw, a_irw, a_ib, a_db;
  logic b_sif, b_sid, b_sem, b_fif, b_fid, b_fmw, b_pcw, b_irw, b_ib, b_db;
  logic [9:0] a_vec, b_vec;
  assign a_vec = {a_sif, a_sid, a_sem, a_fif, a_fid, a_fmw, a_pcw, a_irw, a_ib, a_db};
  assign b_vec = {b_sif, b_sid, b_sem, b_fif, b_fid, b_fmw, b_pcw, b_irw, b_ib, b_db};

  hazard_latency_ctrl #(
    .REG_AW(2), .DATA_FORWARDING(1), .IMEM_LAT(4), .DMEM_LAT(4)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func_code(func_code),
    .rs_id(rs_id), .rt_id(rt_id), .reg_write_ex(reg_write_ex), .reg_write_mem(reg_write_mem),
    .dest_ex(dest_ex), .dest_mem(dest_mem), .mem_read_ex(mem_read_ex),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem), .rt_ex(rt_ex), .rt_mem(rt_mem),
    .jump_miss(jump_miss), .branch_miss(branch_miss),
    .stall_ifid(a_sif), .stall_idex(a_sid), .stall_exmem(a_sem), .flush_ifid(a_fif),
    .flush_idex(a_fid), .flush_memwb(a_fmw), .pc_write(a_pcw), .ir_write(a_irw),
    .imem_busy(a_ib), .dmem_busy(a_db)
  );

  hazard_latency_ctrl #(
    .REG_AW(2), .DATA_FORWARDING(0), .IMEM_LAT(1), .DMEM_LAT(1)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func_code(func_code),
    .rs_id(rs_id), .rt_id(rt_id), .reg_write_ex(reg_write_ex), .reg_write_mem(reg_write_mem),
    .dest_ex(dest_ex), .dest_mem(dest_mem), .mem_read_ex(mem_read_ex),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem), .rt_ex(rt_ex), .rt_mem(rt_mem),
    .jump_miss(jump_miss), .branch_miss(branch_miss),
    .stall_ifid(b_sif), .stall_idex(b_sid), .stall_exmem(b_sem), .flush_ifid(b_fif),
    .flush_idex(b_fid), .flush_memwb(b_fmw), .pc_write(b_pcw), .ir_write(b_irw),
    .imem_busy(b_ib), .dmem_busy(b_db)
  );

  typedef struct {
    string      name;
    bit         sel_b;
    logic [9:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic idle_inputs();
    opcode        = T_JMP;
    func_code     = 6'd0;
    rs_id         = 2'd0;
    rt_id         = 2'd0;
    dest_ex       = 2'd0;
    dest_mem      = 2'd0;
    rt_ex         = 2'd0;
    rt_mem        = 2'd0;
    reg_write_ex  = 1'b0;
    reg_write_mem = 1'b0;
    mem_read_ex   = 1'b0;
    mem_read_mem  = 1'b0;
    mem_write_mem = 1'b0;
    jump_miss     = 1'b0;
    branch_miss   = 1'b0;
  endtask

  // Record the expectation for the inputs currently driven, then advance one cycle.
  task automatic step(input string name, input bit sel_b, input logic [7:0] p,
                      input bit ib, input bit db);
    sb_t e;
    e.name  = name;
    e.sel_b = sel_b;
    e.exp   = {p, ib, db};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Monitor: compare the mid-cycle outputs against the oldest expectation.
  initial begin
    sb_t        e;
    logic [9:0] got;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = e.sel_b ? b_vec : a_vec;
        n_vec++;
        if (got !== e.exp) begin
          n_bad++;
          $display("FAIL %s dut=%s got=%b required=%b", e.name, e.sel_b ? "B" : "A", got, e.exp);
        end else begin
          $display("vec %-12s dut=%s out=%b ok", e.name, e.sel_b ? "B" : "A", got);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    step("rst0", 0, P_DEF, 0, 0);
    step("rst1", 0, P_DEF, 0, 0);
    reset_n = 1'b1;
    // Fetch FSM cycles IDLE, BUSY x3, DONE.
    step("i_idle", 0, P_DEF, 0, 0);
    step("i_busy1", 0, P_IB, 1, 0);
    step("i_busy2", 0, P_IB, 1, 0);
    step("i_busy3", 0, P_IB, 1, 0);
    step("i_done", 0, P_DEF, 0, 0);
    // Load-use stall together with a branch miss: stall wins, fetch held.
    opcode = T_LWD; rs_id = 2'd1; mem_read_ex = 1'b1; rt_ex = 2'd1; branch_miss = 1'b1;
    step("ld_vs_br", 0, P_HAZ, 0, 0);
    step("i_start", 0, P_DEF, 0, 0);
    step("i_busy1b", 0, P_IB, 1, 0);
    // Jump miss in the second BUSY cycle aborts, then a full fetch follows.
    jump_miss = 1'b1;
    step("jmp_abort", 0, P_JMP, 1, 0);
    step("refetch", 0, P_DEF, 0, 0);
    step("rf_busy1", 0, P_IB, 1, 0);
    step("rf_busy2", 0, P_IB, 1, 0);
    step("rf_busy3", 0, P_IB, 1, 0);
    step("rf_done", 0, P_DEF, 0, 0);
    // Data access: three BUSY cycles, accesses during BUSY/DONE ignored.
    mem_read_mem = 1'b1;
    step("d_start", 0, P_DEF, 0, 0);
    step("d_busy1", 0, P_DST, 1, 1);
    mem_write_mem = 1'b1;
    step("d_busy2ign", 0, P_DST, 1, 1);
    step("d_busy3", 0, P_DST, 1, 1);
    mem_read_mem = 1'b1;
    step("d_doneign", 0, P_DEF, 0, 0);
    step("d_idle", 0, P_DEF, 0, 0);
    branch_miss = 1'b1;
    step("br_abort", 0, P_BR, 1, 0);
    step("br_refetch", 0, P_DEF, 0, 0);
    // Reset in the middle of a data access.
    mem_read_mem = 1'b1;
    step("d_start2", 0, P_IB, 1, 0);
    reset_n = 1'b0;
    step("rst_mid", 0, P_DEF, 0, 0);
    reset_n = 1'b1;
    step("post_rst", 0, P_DEF, 0, 0);
    // Jump-register hazard still stalls with forwarding.
    opcode = T_RTY; func_code = T_JPR; rs_id = 2'd3; reg_write_mem = 1'b1; dest_mem = 2'd3;
    step("jr_stall", 0, P_HAZ, 1, 0);
    step("jr_busy2", 0, P_IB, 1, 0);
    step("jr_busy3", 0, P_IB, 1, 0);
    step("jr_done", 0, P_DEF, 0, 0);
    opcode = T_RTY; func_code = T_ADD; rs_id = 2'd2; reg_write_ex = 1'b1; dest_ex = 2'd2;
    step("fwd_no_raw", 0, P_DEF, 0, 0);
    // DUT B: no forwarding, single-cycle memories.
    opcode = T_RTY; func_code = T_ADD; rs_id = 2'd2; reg_write_ex = 1'b1; dest_ex = 2'd2;
    step("raw_ex_rs", 1, P_HAZ, 0, 0);
    opcode = T_RTY; func_code = T_ADD; rs_id = 2'd1; rt_id = 2'd3;
    reg_write_mem = 1'b1; dest_mem = 2'd3;
    step("raw_mem_rt", 1, P_HAZ, 0, 0);
    opcode = T_RTY; func_code = T_ADD; rs_id = 2'd2; dest_ex = 2'd2;
    step("no_wr", 1, P_DEF, 0, 0);
    mem_read_mem = 1'b1;
    step("d_lat1", 1, P_DEF, 0, 0);
    opcode = T_ADI; rs_id = 2'd0; rt_id = 2'd2; reg_write_ex = 1'b1; dest_ex = 2'd2;
    step("adi_rt", 1, P_DEF, 0, 0);
    jump_miss = 1'b1;
    step("jmp_b", 1, P_JMP, 0, 0);
    step("thru1", 1, P_DEF, 0, 0);
    step("thru2", 1, P_DEF, 0, 0);
    step("thru3", 1, P_DEF, 0, 0);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
